// File: rtl/regfile_sb_if.sv
// Read/writeback/issue bundle for regfile_sb.
// The master drives addresses, writeback and issue; the slave returns read data, busy flags and ready.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NRD  = 2,
  parameter int AW   = 5
);
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_rd;
  logic                ready;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd,
    input  rd_data, rd_busy, ready
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd,
    output rd_data, rd_busy, ready
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with NRD combinational read ports, optional write bypass and a pending-write scoreboard.
// States: INIT = sweep zeroes mem/sb[cnt] one register per edge, outputs gated | RUN = normal operation.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREG);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] sb_q;

  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [XLEN-1:0] mem_wd;
  logic            sb_clr, sb_set;
  logic [AW-1:0]   sb_clr_a, sb_set_a;
  logic            run;

  assign run       = (state_q == S_RUN);
  assign bus.ready = ready_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    mem_we   = 1'b0;
    mem_wa   = bus.wr_addr;
    mem_wd   = bus.wr_data;
    sb_clr   = 1'b0;
    sb_clr_a = bus.wr_addr;
    sb_set   = 1'b0;
    sb_set_a = bus.iss_rd;
    case (state_q)
      S_INIT: begin
        mem_we   = 1'b1;
        mem_wa   = cnt_q;
        mem_wd   = '0;
        sb_clr   = 1'b1;
        sb_clr_a = cnt_q;
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = S_RUN;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (bus.wr_en && (bus.wr_addr != '0)) begin
          mem_we = 1'b1;
          sb_clr = 1'b1;
        end
        if (bus.iss_en && (bus.iss_rd != '0)) sb_set = 1'b1;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Array and scoreboard have no reset of their own; the sweep initialises them.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[mem_wa] <= mem_wd;
  end

  // Set is applied after clear so a same-edge issue wins over the writeback.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sb_clr) sb_q[sb_clr_a] <= 1'b0;
      if (sb_set) sb_q[sb_set_a] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          valid;
    logic          byp;
    assign ra    = bus.rd_addr[k*AW +: AW];
    assign valid = run && (ra != '0);
    assign byp   = (BYPASS != 0) && valid && bus.wr_en && (bus.wr_addr == ra);
    assign bus.rd_data[k*XLEN +: XLEN] = !valid ? '0 : (byp ? bus.wr_data : mem_q[ra]);
    assign bus.rd_busy[k] = valid && !byp && sb_q[ra];
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized checks of regfile_sb in three configurations, with an array-based reference model.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_sb_if #(.XLEN(32), .NRD(2), .AW(5)) ifa ();
  regfile_sb_if #(.XLEN(32), .NRD(2), .AW(5)) ifb ();
  regfile_sb_if #(.XLEN(64), .NRD(3), .AW(4)) ifc ();

  regfile_sb #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  regfile_sb #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0)) u_b (.clk(clk), .rst(rst), .bus(ifb));
  regfile_sb #(.XLEN(64), .NREG(16), .NRD(3), .BYPASS(1)) u_c (.clk(clk), .rst(rst), .bus(ifc));

  logic [63:0] mdl_mem [16];
  logic        mdl_sb  [16];

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.iss_en = 1'b0; ifa.iss_rd = '0;
    ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.iss_en = 1'b0; ifb.iss_rd = '0;
    ifc.wr_en = 1'b0; ifc.wr_addr = '0; ifc.wr_data = '0; ifc.iss_en = 1'b0; ifc.iss_rd = '0;
  endtask

  // One RUN cycle on the 64-bit/16-reg/3-port instance, checked against the model.
  task automatic c_cycle(input logic wen, input logic [3:0] wa, input logic [63:0] wd,
                         input logic ien, input logic [3:0] ird, input logic [11:0] ras);
    logic [191:0] exp_d;
    logic [2:0]   exp_b;
    logic [3:0]   ra;
    ifc.wr_en = wen; ifc.wr_addr = wa; ifc.wr_data = wd;
    ifc.iss_en = ien; ifc.iss_rd = ird; ifc.rd_addr = ras;
    exp_d = '0;
    exp_b = '0;
    for (int k = 0; k < 3; k++) begin
      ra = ras[k*4 +: 4];
      if (ra != 4'd0) begin
        if (wen && (wa == ra)) begin
          exp_d[k*64 +: 64] = wd;
        end else begin
          exp_d[k*64 +: 64] = mdl_mem[ra];
          exp_b[k]          = mdl_sb[ra];
        end
      end
    end
    #1;
    chk("c_rd_data", 192'(ifc.rd_data), exp_d);
    chk("c_rd_busy", 192'(ifc.rd_busy), 192'(exp_b));
    @(posedge clk); #1;
    if (wen && (wa != 4'd0)) begin
      mdl_mem[wa] = wd;
      mdl_sb[wa]  = 1'b0;
    end
    if (ien && (ird != 4'd0)) mdl_sb[ird] = 1'b1;
    ifc.wr_en = 1'b0; ifc.iss_en = 1'b0;
  endtask

  initial begin
    int first_a, first_b, first_c;
    logic [63:0] init_d;
    logic [1:0]  init_b;

    rst = 1'b1;
    idle();
    ifa.rd_addr = '0; ifb.rd_addr = '0; ifc.rd_addr = '0;

    // Power-on reset and first sweep
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_a", 192'(ifa.ready), 192'(0));
    rst = 1'b0;
    first_a = 0; first_b = 0; first_c = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ifa.ready && first_a == 0) first_a = i;
      if (ifb.ready && first_b == 0) first_b = i;
      if (ifc.ready && first_c == 0) first_c = i;
    end
    chk("ready_edges_a", 192'(first_a), 192'(32));
    chk("ready_edges_b", 192'(first_b), 192'(32));
    chk("ready_edges_c", 192'(first_c), 192'(16));
    ifa.rd_addr = {5'd17, 5'd31};
    #1;
    chk("swept_data", 192'(ifa.rd_data), 192'(0));
    chk("swept_busy", 192'(ifa.rd_busy), 192'(0));

    // Write, read back, and x0 hardwiring
    ifa.wr_en = 1'b1; ifa.wr_addr = 5'd5; ifa.wr_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    idle();
    ifa.rd_addr = {5'd0, 5'd5};
    #1;
    chk("rd_x5_x0", 192'(ifa.rd_data), 192'({32'h0, 32'hDEADBEEF}));
    ifa.wr_en = 1'b1; ifa.wr_addr = 5'd0; ifa.wr_data = 32'h1234;
    ifa.rd_addr = {5'd0, 5'd0};
    #1;
    chk("x0_no_bypass", 192'(ifa.rd_data), 192'(0));
    @(posedge clk); #1;
    idle();
    #1;
    chk("x0_after_wr", 192'(ifa.rd_data), 192'(0));

    // Bypass on A, none on B
    ifb.wr_en = 1'b1; ifb.wr_addr = 5'd7; ifb.wr_data = 32'h0BADF00D;
    @(posedge clk); #1;
    idle();
    ifa.wr_en = 1'b1; ifa.wr_addr = 5'd7; ifa.wr_data = 32'hA5A5A5A5; ifa.rd_addr = {5'd0, 5'd7};
    ifb.wr_en = 1'b1; ifb.wr_addr = 5'd7; ifb.wr_data = 32'hA5A5A5A5; ifb.rd_addr = {5'd0, 5'd7};
    #1;
    chk("bypass_a", 192'(ifa.rd_data), 192'({32'h0, 32'hA5A5A5A5}));
    chk("nobypass_b", 192'(ifb.rd_data), 192'({32'h0, 32'h0BADF00D}));
    @(posedge clk); #1;
    idle();
    #1;
    chk("after_wr_b", 192'(ifb.rd_data), 192'({32'h0, 32'hA5A5A5A5}));

    // Scoreboard on A
    ifa.iss_en = 1'b1; ifa.iss_rd = 5'd3;
    ifb.iss_en = 1'b1; ifb.iss_rd = 5'd3;
    @(posedge clk); #1;
    idle();
    ifa.rd_addr = {5'd3, 5'd3};
    ifb.rd_addr = {5'd3, 5'd3};
    #1;
    chk("busy_after_iss", 192'(ifa.rd_busy), 192'(2'b11));
    ifa.wr_en = 1'b1; ifa.wr_addr = 5'd3; ifa.wr_data = 32'h11;
    ifb.wr_en = 1'b1; ifb.wr_addr = 5'd3; ifb.wr_data = 32'h33;
    #1;
    chk("busy_masked_a", 192'(ifa.rd_busy), 192'(2'b00));
    chk("data_byp_a", 192'(ifa.rd_data), 192'({32'h11, 32'h11}));
    chk("busy_unmasked_b", 192'(ifb.rd_busy), 192'(2'b11));
    chk("data_old_b", 192'(ifb.rd_data), 192'(0));
    @(posedge clk); #1;
    idle();
    #1;
    chk("busy_clr_a", 192'(ifa.rd_busy), 192'(2'b00));
    chk("data_x3_a", 192'(ifa.rd_data), 192'({32'h11, 32'h11}));
    chk("busy_clr_b", 192'(ifb.rd_busy), 192'(2'b00));
    ifa.iss_en = 1'b1; ifa.iss_rd = 5'd3;
    ifa.wr_en = 1'b1; ifa.wr_addr = 5'd3; ifa.wr_data = 32'h22;
    @(posedge clk); #1;
    idle();
    #1;
    chk("iss_wr_data", 192'(ifa.rd_data), 192'({32'h22, 32'h22}));
    chk("iss_wr_busy", 192'(ifa.rd_busy), 192'(2'b11));
    ifa.iss_en = 1'b1; ifa.iss_rd = 5'd0;
    @(posedge clk); #1;
    idle();
    ifa.rd_addr = {5'd3, 5'd0};
    #1;
    chk("x0_never_busy", 192'(ifa.rd_busy), 192'(2'b10));

    // Reset mid-sweep, then writes/issues during INIT are ignored
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_sweep_ready", 192'(ifa.ready), 192'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    first_a = 0; first_c = 0;
    init_d = '1; init_b = '1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 6) begin
        ifa.wr_en = 1'b1; ifa.wr_addr = 5'd3; ifa.wr_data = 32'hCAFEF00D;
        ifa.iss_en = 1'b1; ifa.iss_rd = 5'd2;
        ifa.rd_addr = {5'd3, 5'd5};
        #1;
        init_d = 64'(ifa.rd_data);
        init_b = ifa.rd_busy;
      end
      @(posedge clk); #1;
      idle();
      if (ifa.ready && first_a == 0) first_a = i;
      if (ifc.ready && first_c == 0) first_c = i;
    end
    chk("init_rd_gated", 192'(init_d), 192'(0));
    chk("init_busy_gated", 192'(init_b), 192'(0));
    chk("restart_edges_a", 192'(first_a), 192'(32));
    chk("restart_edges_c", 192'(first_c), 192'(16));
    ifa.rd_addr = {5'd2, 5'd3};
    #1;
    chk("init_wr_ignored", 192'(ifa.rd_data), 192'(0));
    chk("init_iss_ignored", 192'(ifa.rd_busy), 192'(0));
    ifa.rd_addr = {5'd7, 5'd5};
    #1;
    chk("resweep_cleared", 192'(ifa.rd_data), 192'(0));

    // Wide configuration: directed reads then random traffic vs model
    for (int r = 0; r < 16; r++) begin
      mdl_mem[r] = '0;
      mdl_sb[r]  = 1'b0;
    end
    c_cycle(1'b1, 4'd1, 64'h0123456789ABCDEF, 1'b0, 4'd0, 12'h0);
    c_cycle(1'b1, 4'd15, 64'hFEDCBA9876543210, 1'b0, 4'd0, 12'h0);
    ifc.rd_addr = {4'd15, 4'd1, 4'd1};
    #1;
    chk("c_x1_x1_x15", 192'(ifc.rd_data),
        {64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF});
    for (int n = 0; n < 400; n++) begin
      c_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), {$urandom, $urandom},
              ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), 12'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
